// File: rtl/icache_prefetch_queue.sv
// Prefetch request queue between the icache prefetch engine and the memory port.
// Deduplicates by cache line, lets demand misses squash queued lines, throttles issue.
package icache_pkg;
    localparam int ADDR_WIDTH = 32;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [3:0]            opcode;
        logic [7:0]            txnid;
    } pc_req_t;
endpackage

module icache_prefetch_queue
    import icache_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int LINE_OFFSET     = 6
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    pf_req_vld,
    output logic    pf_req_rdy,
    input  pc_req_t pf_req_pld,
    input  logic    dmd_req_vld,
    output logic    dmd_req_rdy,
    input  pc_req_t dmd_req_pld,
    output logic    mem_req_vld,
    input  logic    mem_req_rdy,
    output pc_req_t mem_req_pld,
    input  logic    pf_rsp_vld,
    input  logic    flush,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] pf_outstanding,
    output logic    pf_dup_drop
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int LW = ADDR_WIDTH - LINE_OFFSET;

    typedef logic [LW-1:0] line_t;

    pc_req_t          mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    hd_q, hd_d, tl_q, tl_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OW-1:0]    out_q, out_d;
    logic             lv_q, lv_d;
    line_t            ll_q, ll_d;
    logic             dup_q;

    logic [PW-1:0]    off [DEPTH];
    logic [DEPTH-1:0] alloc;
    logic             full, head_alloc, head_v;
    logic             pf_present, pf_hs, dmd_hs, push_hs;
    logic             pop, wr, wr_v, dup, fifo_hit, dmd_hit;
    line_t            pf_line, dmd_line;

    assign pf_line    = pf_req_pld.addr[ADDR_WIDTH-1:LINE_OFFSET];
    assign dmd_line   = dmd_req_pld.addr[ADDR_WIDTH-1:LINE_OFFSET];

    assign full       = (cnt_q == CW'(DEPTH));
    assign pf_req_rdy = !full;
    assign head_alloc = (cnt_q != '0);
    assign head_v     = vld_q[hd_q];

    assign dmd_req_rdy = mem_req_rdy;
    assign pf_present  = !dmd_req_vld && head_alloc && head_v
                       && (out_q < OW'(MAX_OUTSTANDING));
    assign mem_req_vld = dmd_req_vld || pf_present;
    assign mem_req_pld = dmd_req_vld ? dmd_req_pld : mem_q[hd_q];

    assign dmd_hs  = dmd_req_vld && mem_req_rdy;
    assign pf_hs   = pf_present && mem_req_rdy;
    assign push_hs = pf_req_vld && pf_req_rdy;
    assign pop     = pf_hs || (head_alloc && !head_v);

    // Allocation is judged from the head offset so freed slots never match.
    always_comb begin
        fifo_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off[i]   = PW'(i) - hd_q;
            alloc[i] = ({1'b0, off[i]} < cnt_q);
            if (alloc[i] && vld_q[i]
                && mem_q[i].addr[ADDR_WIDTH-1:LINE_OFFSET] == pf_line) begin
                fifo_hit = 1'b1;
            end
        end
    end

    assign dmd_hit = lv_q && (ll_q == pf_line);
    assign dup     = push_hs && !flush && (fifo_hit || dmd_hit);
    assign wr      = push_hs && !flush && !dup;
    assign wr_v    = !(dmd_hs && (dmd_line == pf_line));

    always_comb begin
        vld_d = vld_q;
        hd_d  = hd_q;
        tl_d  = tl_q;
        cnt_d = cnt_q;
        out_d = out_q;
        lv_d  = lv_q;
        ll_d  = ll_q;
        if (dmd_hs) begin
            lv_d = 1'b1;
            ll_d = dmd_line;
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].addr[ADDR_WIDTH-1:LINE_OFFSET] == dmd_line) begin
                    vld_d[i] = 1'b0;
                end
            end
        end
        if (wr) begin
            vld_d[tl_q] = wr_v;
            tl_d        = tl_q + PW'(1);
        end
        if (pop) begin
            hd_d = hd_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(wr) - CW'(pop);
        if (flush) begin
            hd_d  = '0;
            tl_d  = '0;
            cnt_d = '0;
        end
        case ({pf_hs, pf_rsp_vld && (out_q != '0)})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            hd_q  <= '0;
            tl_q  <= '0;
            cnt_q <= '0;
            out_q <= '0;
            lv_q  <= 1'b0;
            ll_q  <= '0;
            dup_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            hd_q  <= hd_d;
            tl_q  <= tl_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
            lv_q  <= lv_d;
            ll_q  <= ll_d;
            dup_q <= dup;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[tl_q] <= pf_req_pld;
        end
    end

    assign pf_outstanding = out_q;
    assign pf_dup_drop    = dup_q;
endmodule

// File: doc/icache_prefetch_queue.md
# icache_prefetch_queue

Sits directly downstream of the icache prefetch engine and upstream of the icache downstream memory-request port. Buffers next-line prefetch requests in a small FIFO, drops duplicates, and squashes queued prefetches that a demand miss has already covered. Merges prefetches with demand-miss requests onto one memory port, with demand given strict priority. Throttles prefetch issue to a bounded number of outstanding prefetches.

## Interface
Parameters:
- DEPTH, 4: prefetch FIFO entries; power of two, ≥2.
- MAX_OUTSTANDING, 2: maximum issued-but-unreturned prefetches; ≥1.
- LINE_OFFSET, 6: low address bits ignored for line compare (64 B line).

Ports (reset is asynchronous and active-high; one clock):
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- pf_req_vld  in  1  prefetch request valid.
- pf_req_rdy  out  1  prefetch request accepted; depends only on registered state, never on pf_req_vld.
- pf_req_pld  in  pc_req_t  prefetch request (addr, opcode, txnid).
- dmd_req_vld  in  1  demand-miss request valid.
- dmd_req_rdy  out  1  demand request accepted.
- dmd_req_pld  in  pc_req_t  demand-miss request.
- mem_req_vld  out  1  request to the memory side.
- mem_req_rdy  in  1  memory side accepts.
- mem_req_pld  out  pc_req_t  request payload.
- pf_rsp_vld  in  1  one prefetch completion returned.
- flush  in  1  discard all queued prefetches.
- pf_outstanding  out  $clog2(MAX_OUTSTANDING+1)  issued prefetches not yet returned.
- pf_dup_drop  out  1  one-cycle pulse when an accepted prefetch is discarded as a duplicate.

## Operation
- Line address is defined as addr[ADDR_WIDTH-1:LINE_OFFSET]. Each FIFO entry holds a pc_req_t plus a valid bit.
- pf_req_rdy is !full. Full means DEPTH entries are allocated, valid or not.
- Accept rule: a handshake (pf_req_vld && pf_req_rdy) writes the tail with valid=1 unless one of the following holds:
  - the line matches any allocated valid entry;
  - the line matches last_dmd_line (line of the most recent demand handshake, once one has occurred);
  - flush is high.
- In the first two cases the request is not written and pf_dup_drop pulses the next cycle. A flush-cycle drop does not pulse.
- Demand path (combinational):
  - dmd_req_rdy = mem_req_rdy.
  - When dmd_req_vld is high, mem_req_vld=1 and mem_req_pld = dmd_req_pld.
- Demand handshake side effects: last_dmd_line is updated, and every FIFO entry whose line equals the demand line gets valid=0 (squash).
- Prefetch issue:
  - When dmd_req_vld=0, the head is allocated, head valid=1 and pf_outstanding < MAX_OUTSTANDING, then mem_req_vld=1 and mem_req_pld = head payload, unchanged.
  - A handshake pops the head.
- Invalid head: an allocated head with valid=0 is popped with mem_req_vld=0 from the prefetch side, one entry per cycle.
- The mem port is non-sticky. A presented prefetch may be withdrawn when a demand arrives; the payload is meaningful only in a handshake cycle.
- pf_outstanding:
  - increments on a prefetch issue handshake and decrements on pf_rsp_vld;
  - both in the same cycle leaves it unchanged;
  - pf_rsp_vld at 0 is ignored (saturates at 0).
- flush: all entries are deallocated and the pointers are reset at the next edge. pf_outstanding and last_dmd_line are unaffected. A prefetch handshake on the mem port in the flush cycle completes and counts.

## Timing
- Reset values: FIFO empty, pf_req_rdy=1, pf_outstanding=0, pf_dup_drop=0, last_dmd_line invalid. mem_req_vld equals dmd_req_vld.
- Demand latency: 0 cycles, combinational through to the mem port.
- Prefetch latency: accepted in cycle N, presented on the mem port no earlier than N+1. There is no write-to-read bypass.
- Simultaneous push and pop when full: rdy is already 0, so no push occurs.
- Simultaneous push and pop when not full: both take effect and the occupancy is unchanged.
- Dedup compare uses the pre-edge contents, including a head being popped that same cycle. A match with that head is dropped as a duplicate.
- Demand squash and a prefetch push of the same line in the same cycle: the push matches last_dmd_line only from the next cycle. The new entry is squashed by the same-cycle demand compare, because the squash is also applied to the write data.
- Reset asserted mid-operation clears all state asynchronously. Queued prefetches are lost without any response.

## Test plan
- Reset then push 0x1000, 0x2000, 0x3000, 0x4000 with mem_req_rdy=0 → pf_req_rdy=0 after the 4th push. Raise mem_req_rdy → mem issues 0x1000 and 0x2000, then stalls with pf_outstanding=2. Pulse pf_rsp_vld → 0x3000 issues.
- Push 0x1040 twice, second push at 0x1070 (same line) → one entry only, and pf_dup_drop pulses once.
- Queue 0x5000 with pf_outstanding=MAX, then demand 0x5020 handshakes → entry squashed, no prefetch to 0x5000 ever issued, and a later push of 0x5000 is dropped as a duplicate.
- dmd_req_vld and a ready prefetch head in the same cycle, mem_req_rdy=1 → demand payload issued, head retained and issued next cycle, pf_outstanding +1 only then.
- Flush with 3 entries queued while the head handshakes and a push arrives → head issue counts (pf_outstanding +1), push dropped with no pf_dup_drop, FIFO empty next cycle.
- pf_rsp_vld and a prefetch issue in the same cycle at pf_outstanding=1 → remains 1. pf_rsp_vld at 0 → remains 0.
